key_step_pulse: RTL
===================

// Module: key_step_pulse
// PURPOSE
//   Converts a raw, bouncy push-button into clean single-cycle step pulses
//   for the 8-bit LFSR/hex-display stage. step drives that stage's en input
//   directly: one LFSR advance per press, plus optional auto-repeat while held.
//   Also keeps an 8-bit wrapping count of every step issued.
// PARAMETERS
//   DEBOUNCE_CYCLES  4        consecutive stable cycles needed to accept a level change (>=1)
//   REPEAT_DELAY     8        cycles held after the first step before auto-repeat starts (>=2)
//   REPEAT_PERIOD    4        cycles between auto-repeat steps (>=2)
//   CNT_W            16       width of internal debounce/repeat counters; must hold every parameter above
// PORTS
//   clk        in   1  system clock; everything updates on posedge
//   reset      in   1  synchronous, active-high reset
//   key_in     in   1  raw button, active-high, asynchronous to clk
//   auto_en    in   1  1 = auto-repeat enabled while the key is held
//   step       out  1  registered one-cycle pulse; connect to the LFSR en input
//   key_level  out  1  debounced key level, registered
//   step_cnt   out  8  total steps issued, wraps 255->0
// BEHAVIOUR
//   Reset (reset=1 at an edge): clears sync flops, key_level, step, step_cnt and
//     both counters; FSM->IDLE. Reset wins over every other event, including mid-hold.
//   Synchroniser: two flops, key_in -> s1 -> s2. Only s2 is used downstream.
//   Debounce: dcnt increments on each edge where s2 != key_level.
//     It clears to 0 on any edge where s2 == key_level.
//     On the edge where s2 != key_level and dcnt == DEBOUNCE_CYCLES-1:
//     key_level <= s2 and dcnt <= 0.
//     key_in rising before edge k (held) -> key_level = 1 after edge k+1+DEBOUNCE_CYCLES.
//     Glitches shorter than DEBOUNCE_CYCLES cycles at s2 are ignored.
//   FSM (rcnt = repeat counter):
//     IDLE:   key_level rises -> step=1 on the same edge, rcnt<=0, go HOLD.
//     HOLD:   key_level falls -> IDLE (no step).
//             Else if auto_en and rcnt == REPEAT_DELAY-1 -> step=1, rcnt<=0, go REPEAT.
//             Else rcnt++ (saturates at REPEAT_DELAY-1 while auto_en=0).
//     REPEAT: key_level falls -> IDLE.
//             Else if auto_en=0 -> HOLD with rcnt<=0, no step.
//             Else if rcnt == REPEAT_PERIOD-1 -> step=1, rcnt<=0.
//             Else rcnt++.
//   step is 0 in every cycle not named above, so it is never high in two
//     consecutive cycles.
//   step_cnt increments by 1 on each edge that sets step=1 (mod 256).
//   Release and re-press are each independently debounced; a new first step
//     needs a full release to IDLE and then a new rising edge of key_level.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
//   1 reset=1 two cycles -> step=0, key_level=0, step_cnt=0; hold key_in=1
//     during reset -> still 0 until reset drops.
//   2 key_in 0->1 before edge k, held 20 cycles, auto_en=0 -> key_level and
//     step=1 after edge k+5, step high exactly one cycle, step_cnt=1.
//   3 key_in pulses high 3 cycles then low -> no key_level change, no step,
//     step_cnt unchanged.
//   4 key held, auto_en=1 -> steps at k+5, k+13, k+17, k+21...; release ->
//     steps stop within 1+4+1 cycles, step_cnt equals the number of pulses.
//   5 auto_en dropped mid-REPEAT -> no further steps while held; raising it
//     again -> next step 8 cycles later.
//   6 256 single presses -> step_cnt wraps to 0; reset asserted mid-hold ->
//     IDLE, no step, step_cnt=0.

Source files
------------

// File: rtl/key_step_pulse.sv
// Push-button front end: synchronise, debounce, then turn each accepted press
// into one-cycle step pulses with optional auto-repeat and a wrapping step count.
module key_step_pulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    input  logic       auto_en,
    output logic       step,
    output logic       key_level,
    output logic [7:0] step_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             accept;
    logic             key_rise, key_fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             step_q, step_d;
    logic [7:0]       step_cnt_q, step_cnt_d;

    // Two-flop synchroniser; only s2_q is seen by the rest of the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= key_in;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        level_d = level_q;
        dcnt_d  = '0;
        accept  = 1'b0;
        if (s2_q != level_q) begin
            if (dcnt_q == DB_LAST) begin
                accept  = 1'b1;
                level_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + CNT_ONE;
            end
        end
    end

    // Edge events fire on the same clock edge that updates key_level.
    assign key_rise = accept & s2_q;
    assign key_fall = accept & ~s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        step_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_rise) begin
                    step_d  = 1'b1;
                    rcnt_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (key_fall) begin
                    state_d = ST_IDLE;
                end else if (rcnt_q == RD_LAST) begin
                    // Counter parks at the last value until auto-repeat is enabled.
                    if (auto_en) begin
                        step_d  = 1'b1;
                        rcnt_d  = '0;
                        state_d = ST_REPEAT;
                    end
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (key_fall) begin
                    state_d = ST_IDLE;
                end else if (!auto_en) begin
                    rcnt_d  = '0;
                    state_d = ST_HOLD;
                end else if (rcnt_q == RP_LAST) begin
                    step_d = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    assign step_cnt_d = step_d ? step_cnt_q + 8'd1 : step_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            step_q     <= 1'b0;
            step_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            step_q     <= step_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step      = step_q;
    assign key_level = level_q;
    assign step_cnt  = step_cnt_q;
    assign dbg_state = state_q;

endmodule
